// File: rtl/rca_seq_pkg.sv
`default_nettype none
// ==========================================================================
// rca_seq_pkg: shared types and constants for the nibble-serial adder.
// Rev 1.0
// ==========================================================================
package rca_seq_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One spare bit so the counter can hold NSLICE itself, including NSLICE=1.
  function automatic int cnt_width(input int nslice);
    return $clog2(nslice) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rca_seq_adder_rca4.sv
`default_nettype none
// ==========================================================================
// rca_seq_adder_rca4: 4-bit ripple-carry slice shared by every nibble.
// Rev 1.0
// ==========================================================================
module rca_seq_adder_rca4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign s[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[4];

endmodule
`default_nettype wire

// File: rtl/rca_seq_adder.sv
`default_nettype none
// ==========================================================================
// rca_seq_adder: WIDTH-bit adder computed one nibble per cycle through a
// single shared RCA4 slice. Define RCA_SEQ_SUB_EN to add the SUB port.
// Rev 1.0
// ==========================================================================
module rca_seq_adder
  import rca_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef RCA_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int CNT_W  = cnt_width(NSLICE);

  if (WIDTH < SLICE_W || (WIDTH % SLICE_W) != 0) begin : g_width_check
    $error("rca_seq_adder: WIDTH must be a positive multiple of 4");
  end

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   op_a, op_b, sum_q, sum_next;
  logic [CNT_W-1:0]   cnt;
  logic               carry_q, a_msb, b_msb;
  logic [WIDTH-1:0]   b_eff;
  logic               c_init;
  logic [SLICE_W-1:0] slice_s;
  logic               slice_cout;
  logic               last_slice;

`ifdef RCA_SEQ_SUB_EN
  assign b_eff  = sub ? ~b : b;
  assign c_init = sub ? 1'b1 : cin;
`else
  assign b_eff  = b;
  assign c_init = cin;
`endif

  assign last_slice = (cnt == CNT_W'(NSLICE - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)   state_d = RUN;
      RUN:     if (last_slice) state_d = DONE;
      DONE:    if (out_ready)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  rca_seq_adder_rca4 u_rca4 (
    .a    (op_a[SLICE_W-1:0]),
    .b    (op_b[SLICE_W-1:0]),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_cout)
  );

  // Each new nibble enters at the top so the LSB nibble lands at bit 0 last.
  if (NSLICE == 1) begin : g_single
    assign sum_next = slice_s;
  end else begin : g_multi
    assign sum_next = {slice_s, sum_q[WIDTH-1:SLICE_W]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a    <= '0;
      op_b    <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      a_msb   <= 1'b0;
      b_msb   <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          op_a    <= a;
          op_b    <= b_eff;
          carry_q <= c_init;
          a_msb   <= a[WIDTH-1];
          b_msb   <= b_eff[WIDTH-1];
          cnt     <= '0;
        end
        RUN: begin
          op_a    <= op_a >> SLICE_W;
          op_b    <= op_b >> SLICE_W;
          sum_q   <= sum_next;
          carry_q <= slice_cout;
          cnt     <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE) & ~rst;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign s         = sum_q;
  assign cout      = carry_q;
  assign ovf       = (a_msb == b_msb) & (sum_q[WIDTH-1] != a_msb);

endmodule
`default_nettype wire
